// File: rtl/aes_pkg.sv
// Shared AES types and constants: word/round-key types, key-expander FSM states,
// the forward S-box and the key-schedule round constants.
package aes_pkg;

  localparam int unsigned NK_WORDS = 8;
  localparam int unsigned NR       = 14;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } kexp_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed by i/8; entry 0 is never used by AES-256.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box byte lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes256_key_expander.sv
// Iterative AES-256 key schedule: one word per cycle into a 60-word register file,
// registered round-key read port. Optional zeroize input under KEYEXP_ZEROIZE_EN.
module aes256_key_expander #(
  parameter int unsigned NK_WORDS = 8,
  parameter int unsigned NR       = 14
) (
  input  logic         clk,
  input  logic         resetn,
`ifdef KEYEXP_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic [3:0]   selectKey,
  output logic [127:0] data,
  output logic         busy,
  output logic         key_ready
);

  import aes_pkg::*;

  localparam int unsigned NumWords = 4 * (NR + 1);

  kexp_state_t state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  word_t       w_q [NumWords];
  word_t       w_d [NumWords];
  rkey_t       data_q, data_d;
  logic        busy_q, busy_d;
  logic        key_ready_q, key_ready_d;

  word_t      prev_w, sub_in, sub_out, new_w;
  logic [5:0] rk_base;

  assign prev_w = w_q[idx_q - 6'd1];
  assign sub_in = (idx_q[2:0] == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .in_i  (sub_in[8*b +: 8]),
      .out_o (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    new_w = w_q[idx_q - 6'd8];
    unique case (idx_q[2:0])
      3'd0:    new_w = new_w ^ sub_out ^ {RCON[idx_q[5:3]], 24'h0};
      3'd4:    new_w = new_w ^ sub_out;
      default: new_w = new_w ^ prev_w;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          for (int k = 0; k < NK_WORDS; k++) begin
            w_d[k] = key_in[255 - 32*k -: 32];
          end
          idx_d   = 6'(NK_WORDS);
          state_d = StExpand;
        end
      end
      StExpand: begin
        w_d[idx_q] = new_w;
        idx_d      = idx_q + 6'd1;
        if (idx_q == 6'(NumWords - 1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reads see pre-write contents: data is built from w_q, not w_d.
    rk_base = {selectKey, 2'b00};
    if ({28'd0, selectKey} > NR) begin
      data_d = '0;
    end else begin
      data_d = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    end

`ifdef KEYEXP_ZEROIZE_EN
    if (zeroize) begin
      state_d = StIdle;
      idx_d   = '0;
      w_d     = '{default: '0};
      data_d  = '0;
    end
`endif

    busy_d      = (state_d == StExpand);
    key_ready_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      for (int k = 0; k < NumWords; k++) begin
        w_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      for (int k = 0; k < NumWords; k++) begin
        w_q[k] <= w_d[k];
      end
    end
  end

  assign data      = data_q;
  assign busy      = busy_q;
  assign key_ready = key_ready_q;

endmodule

// File: tb/tb_aes256_key_expander.sv
// Self-checking bench for aes256_key_expander against an independent key-schedule model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes256_key_expander;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [255:0] key_in;
  logic [3:0]   selectKey;
  logic [127:0] data;
  logic         busy;
  logic         key_ready;
`ifdef KEYEXP_ZEROIZE_EN
  logic         zeroize;
`endif

  aes256_key_expander dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef KEYEXP_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .start     (start),
    .key_in    (key_in),
    .selectKey (selectKey),
    .data      (data),
    .busy      (busy),
    .key_ready (key_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_sbox [256];
  logic [7:0]  m_rcon [8];
  logic [31:0] mw [60];

  localparam logic [255:0] FipsKey =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, rc;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    m_rcon[0] = 8'h00;
    for (int j = 1; j < 8; j++) begin
      m_rcon[j] = rc;
      rc = gmul(rc, 8'h02);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {m_sbox[v[31:24]], m_sbox[v[23:16]], m_sbox[v[15:8]], m_sbox[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = mw[i-1];
      if (i % 8 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {m_rcon[i/8], 24'h0};
      else if (i % 8 == 4) t = sub_word(t);
      mw[i] = mw[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continues counting edges after the start edge until key_ready, bounded.
  task automatic wait_ready(input int n0, output int n);
    n = n0;
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_start(input logic [255:0] key);
    start = 1'b1; key_in = key;
    tick();
    start = 1'b0; key_in = $urandom();
  endtask

  task automatic read_rk(input string tag, input int r, input logic [127:0] exp);
    selectKey = 4'(r);
    tick();
    check_eq(tag, data, exp);
  endtask

  logic [255:0] rkey;
  int           n;

  initial begin
    build_tables();
    resetn = 1'b1; start = 1'b0; key_in = '0; selectKey = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    tick(); tick();
    resetn = 1'b0;
    check_eq("reset_busy", 128'(busy), 128'd0);
    check_eq("reset_ready", 128'(key_ready), 128'd0);
    check_eq("reset_data", data, 128'd0);
    read_rk("reset_storage", 14, 128'd0);

    // FIPS-197 A.3 key
    model_expand(FipsKey);
    pulse_start(FipsKey);
    check_eq("busy_after_start", 128'(busy), 128'd1);
    wait_ready(0, n);
    check_eq("fips_latency", 128'(n), 128'd52);
    check_eq("busy_in_done", 128'(busy), 128'd0);
    read_rk("fips_rk2", 2, 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
    read_rk("fips_rk14", 14, 128'hfe4890d1_e6188d0b_046df344_706c631e);
    read_rk("fips_rk0", 0, 128'h603deb10_15ca71be_2b73aef0_857d7781);
    read_rk("fips_rk1", 1, 128'h1f352c07_3b6108d7_2d9810a3_0914dff4);
    for (int r = 0; r < 15; r++) read_rk("fips_model", r, model_rk(r));
    read_rk("out_of_range", 15, 128'd0);

    // start during EXPAND is ignored
    pulse_start(FipsKey);
    n = 0;
    repeat (9) begin tick(); n++; end
    start = 1'b1; key_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()};
    tick(); n++;
    start = 1'b0;
    wait_ready(n, n);
    check_eq("ignore_latency", 128'(n), 128'd52);
    read_rk("ignore_rk14", 14, 128'hfe4890d1_e6188d0b_046df344_706c631e);

    // reset mid-expansion
    pulse_start(FipsKey);
    repeat (19) tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    check_eq("midrst_busy", 128'(busy), 128'd0);
    check_eq("midrst_ready", 128'(key_ready), 128'd0);
    check_eq("midrst_data", data, 128'd0);
    read_rk("midrst_storage", 0, 128'd0);
    pulse_start(FipsKey);
    wait_ready(0, n);
    check_eq("midrst_latency", 128'(n), 128'd52);
    read_rk("midrst_rk14", 14, 128'hfe4890d1_e6188d0b_046df344_706c631e);

    // re-key from DONE with an all-zero key
    pulse_start('0);
    check_eq("rekey_ready_drop", 128'(key_ready), 128'd0);
    wait_ready(0, n);
    check_eq("rekey_latency", 128'(n), 128'd52);
    read_rk("zero_rk2", 2, 128'h62636363_62636363_62636363_62636363);

    // randomized keys against the model
    for (int k = 0; k < 4; k++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(rkey);
      pulse_start(rkey);
      wait_ready(0, n);
      check_eq("rand_latency", 128'(n), 128'd52);
      for (int j = 0; j < 6; j++) begin
        int r;
        r = int'($urandom_range(0, 15));
        read_rk("rand_rk", r, (r == 15) ? 128'd0 : model_rk(r));
      end
    end

`ifdef KEYEXP_ZEROIZE_EN
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check_eq("zero_ready", 128'(key_ready), 128'd0);
    check_eq("zero_data", data, 128'd0);
    for (int r = 0; r < 15; r++) read_rk("zero_storage", r, 128'd0);
    zeroize = 1'b1; start = 1'b1; key_in = FipsKey;
    tick();
    zeroize = 1'b0; start = 1'b0;
    check_eq("zero_wins_busy", 128'(busy), 128'd0);
    repeat (3) tick();
    check_eq("zero_wins_idle", 128'({busy, key_ready}), 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
